rf_wb_scoreboard: RTL

- Controller for the 32x32 register file's single write port and its read hazards.
- Arbitrates two writeback requesters onto the one write port: A (ALU result) and B (load/memory result).
- Registers the selected write into the regfile write-port signals.
- Keeps a busy-bit scoreboard per architectural register and stalls instruction issue on RAW and WAW hazards until the producing write has committed.

---
 rtl/rf_wb_scoreboard.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rf_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scoreboard
// Purpose  : Write-port controller and hazard scoreboard for a 32x32 register
//            file. Two writeback requesters (A = ALU, B = load/memory) share
//            the single write port. Each architectural register has a busy bit
//            that stalls issue on RAW/WAW hazards until its write commits.
// Ports    : clk_i, rstn_i             - clock, synchronous active-low reset
//            iss_*_i / iss_stall_o     - issue request and combinational stall
//            a_*_i, a_ready_o          - requester A writeback handshake
//            b_*_i, b_ready_o          - requester B writeback handshake
//            rf_we_o/rf_rd_o/
//            rf_rd_data_o              - registered regfile write port
//            busy_o                    - registered scoreboard, bit 0 always 0
//            wb_err_o                  - sticky: writeback to a non-busy reg
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_scoreboard #(
    parameter int XLEN  = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            iss_valid_i,
    input  logic            iss_wb_i,
    input  logic [4:0]      iss_rd_i,
    input  logic [4:0]      iss_rs1_i,
    input  logic [4:0]      iss_rs2_i,
    output logic            iss_stall_o,
    input  logic            a_valid_i,
    output logic            a_ready_o,
    input  logic [4:0]      a_rd_i,
    input  logic [XLEN-1:0] a_data_i,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    input  logic [4:0]      b_rd_i,
    input  logic [XLEN-1:0] b_data_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_rd_data_o,
    output logic [31:0]     busy_o,
    output logic            wb_err_o
);

    logic [31:0]     busy_q,    busy_d;
    logic            rf_we_q,   rf_we_d;
    logic [4:0]      rf_rd_q,   rf_rd_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            wb_err_q,  wb_err_d;
    logic            rr_ptr_q,  rr_ptr_d;   // 0 = A next on contention, 1 = B

    logic            w_a_gnt;
    logic            w_b_gnt;
    logic            w_gnt;
    logic [4:0]      w_gnt_rd;
    logic [XLEN-1:0] w_gnt_data;
    logic            w_issue_set;

    // ------------------------------------------------------------------
    // Writeback arbitration; nothing is granted while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (rstn_i) begin
            if (a_valid_i && b_valid_i) begin
                if (RR_EN && !rr_ptr_q) begin
                    w_a_gnt = 1'b1;
                end else begin
                    w_b_gnt = 1'b1;
                end
            end else begin
                w_a_gnt = a_valid_i;
                w_b_gnt = b_valid_i;
            end
        end
    end

    assign a_ready_o  = w_a_gnt;
    assign b_ready_o  = w_b_gnt;
    assign w_gnt      = w_a_gnt | w_b_gnt;
    assign w_gnt_rd   = w_a_gnt ? a_rd_i   : b_rd_i;
    assign w_gnt_data = w_a_gnt ? a_data_i : b_data_i;

    // Only a contended grant moves the pointer to the loser.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_a_gnt && b_valid_i) begin
            rr_ptr_d = 1'b1;
        end else if (w_b_gnt && a_valid_i) begin
            rr_ptr_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Issue hazard check. busy_q[0] is held at 0, so x0 never stalls.
    // ------------------------------------------------------------------
    assign iss_stall_o = rstn_i && iss_valid_i &&
                         (busy_q[iss_rs1_i] || busy_q[iss_rs2_i] ||
                          (iss_wb_i && busy_q[iss_rd_i]));

    assign w_issue_set = iss_valid_i && !iss_stall_o && iss_wb_i &&
                         (iss_rd_i != 5'd0);

    // ------------------------------------------------------------------
    // Next state for write port, scoreboard and error flag.
    // ------------------------------------------------------------------
    always_comb begin
        rf_we_d   = w_gnt && (w_gnt_rd != 5'd0);
        rf_rd_d   = w_gnt ? w_gnt_rd   : rf_rd_q;
        rf_data_d = w_gnt ? w_gnt_data : rf_data_q;

        wb_err_d  = wb_err_q ||
                    (w_gnt && (w_gnt_rd != 5'd0) && !busy_q[w_gnt_rd]);

        // Clear is applied before set so a same-register collision keeps
        // the register busy for the newer producer.
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (w_issue_set) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            busy_q    <= 32'd0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= 5'd0;
            rf_data_q <= '0;
            wb_err_q  <= 1'b0;
            rr_ptr_q  <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            wb_err_q  <= wb_err_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_rd_o      = rf_rd_q;
    assign rf_rd_data_o = rf_data_q;
    assign busy_o       = busy_q;
    assign wb_err_o     = wb_err_q;

endmodule
`default_nettype wire
